// File: rtl/mem_ctrl_if.sv
// Bundle of signals between mem_ctrl, its two requesters (IF and MEM stage)
// and the byte-wide unified RAM. The controller uses the slave view; the
// pipeline/RAM side uses the master view.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    // instruction fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_data;
    logic              if_done;

    // MEM stage load/store side
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;

    // byte-wide RAM port and status
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_data, if_done,
        output mem_rdata, mem_done,
        output ram_a, ram_dout, ram_wr, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_data, if_done,
        input  mem_rdata, mem_done,
        input  ram_a, ram_dout, ram_wr, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide unified RAM controller. Arbitrates between instruction fetch and
// the MEM stage (MEM has priority), and turns 8/16/32-bit accesses into
// sequential little-endian byte transfers. Each requester gets a registered
// one-cycle done pulse; a port whose done is high is not re-accepted at that
// edge, so a request that is still held after completion is not re-issued.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    logic [1:0]        r_state;
    logic              r_port;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_cyc;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;

    logic              w_mem_go;
    logic              w_if_go;
    logic [2:0]        w_mem_n;
    logic [2:0]        w_cyc_nx;
    logic [1:0]        w_lane;
    logic [31:0]       w_asm;
    logic [ADDR_W-1:0] w_next_a;
    logic [7:0]        w_next_byte;

    // r_cyc counts edges since acceptance; byte k arrives on ram_din in the
    // cycle where r_cyc == k+1, so the lane being captured is r_cyc-1.
    assign w_mem_go    = bus.mem_req && !r_mem_done;
    assign w_if_go     = bus.if_req && !r_if_done && !bus.if_flush;
    assign w_cyc_nx    = r_cyc + 3'd1;
    assign w_lane      = r_cyc[1:0] - 2'd1;
    assign w_next_a    = r_base + ADDR_W'(w_cyc_nx);
    assign w_next_byte = r_wdata[8*w_cyc_nx[1:0] +: 8];

    // Decode transfer length and merge the incoming RAM byte into its lane.
    always_comb begin
        case (bus.mem_size)
            2'd0:    w_mem_n = 3'd1;
            2'd1:    w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
        w_asm = r_asm;
        w_asm[8*w_lane +: 8] = bus.ram_din;
    end

    // Main sequencer: arbitration in IDLE, byte-serial read and write phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_port      <= PORT_IF;
            r_base      <= '0;
            r_n         <= '0;
            r_cyc       <= '0;
            r_wdata     <= '0;
            r_asm       <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_go) begin
                        r_port  <= PORT_MEM;
                        r_base  <= bus.mem_addr;
                        r_n     <= w_mem_n;
                        r_wdata <= bus.mem_wdata;
                        r_cyc   <= '0;
                        r_asm   <= '0;
                        r_ram_a <= bus.mem_addr;
                        if (bus.mem_we) begin
                            r_ram_dout <= bus.mem_wdata[7:0];
                            r_ram_wr   <= 1'b1;
                            r_state    <= S_WR;
                        end else begin
                            r_state    <= S_RD;
                        end
                    end else if (w_if_go) begin
                        r_port  <= PORT_IF;
                        r_base  <= bus.if_addr;
                        r_n     <= 3'd4;
                        r_cyc   <= '0;
                        r_asm   <= '0;
                        r_ram_a <= bus.if_addr;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_port == PORT_IF && bus.if_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc <= w_cyc_nx;
                        if (r_cyc != 3'd0) begin
                            r_asm <= w_asm;
                        end
                        if (w_cyc_nx < r_n) begin
                            r_ram_a <= w_next_a;
                        end
                        if (r_cyc == r_n) begin
                            if (r_port == PORT_MEM) begin
                                r_mem_rdata <= w_asm;
                                r_mem_done  <= 1'b1;
                            end else begin
                                r_if_data   <= w_asm;
                                r_if_done   <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WR: begin
                    if (w_cyc_nx == r_n) begin
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cyc      <= w_cyc_nx;
                        r_ram_a    <= w_next_a;
                        r_ram_dout <= w_next_byte;
                    end
                end
                default: begin
                    r_ram_wr <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_data   = r_if_data;
    assign bus.if_done   = r_if_done;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.mem_done  = r_mem_done;
    assign bus.ram_a     = r_ram_a;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, scoreboard queues for
// fetch/load data, and cycle-level checks of latency, addresses and writes.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] ifExp[$];
    logic [31:0] memExp[$];
    logic [31:0] trA[$];
    logic [31:0] wrA[$];
    logic [7:0]  wrD[$];

    logic [7:0]  ramMem [0:65535];
    logic        prevIfDone;
    logic        prevMemDone;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: read data appears the cycle after the address, writes on the edge.
    always @(posedge clk) begin
        bus.ram_din <= ramMem[bus.ram_a[15:0]];
        if (bus.ram_wr) begin
            ramMem[bus.ram_a[15:0]] = bus.ram_dout;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected value; pulses are one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done) begin
                if (ifExp.size() == 0) checkOutput("if_extra_done", 32'd1, 32'd0);
                else checkOutput("if_data", bus.if_data, ifExp.pop_front());
                if (prevIfDone) checkOutput("if_pulse_len", 32'd2, 32'd1);
            end
            if (bus.mem_done) begin
                if (memExp.size() == 0) checkOutput("mem_extra_done", 32'd1, 32'd0);
                else checkOutput("mem_rdata", bus.mem_rdata, memExp.pop_front());
                if (prevMemDone) checkOutput("mem_pulse_len", 32'd2, 32'd1);
            end
        end
        prevIfDone  <= bus.if_done;
        prevMemDone <= bus.mem_done;
    end

    // Drive one request on an idle controller and trace it until its done.
    // doneAt is the number of edges after the accept edge (sampled #1 after each).
    task automatic applyStimulus(input bit isMem, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int doneAt);
        trA.delete();
        wrA.delete();
        wrD.delete();
        doneAt = -1;
        if (isMem) begin
            bus.mem_we    = we;
            bus.mem_size  = size;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
            bus.mem_req   = 1'b1;
        end else begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end
        @(posedge clk); #1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            trA.push_back(bus.ram_a);
            if (bus.ram_wr) begin
                wrA.push_back(bus.ram_a);
                wrD.push_back(bus.ram_dout);
            end
            if (isMem ? bus.mem_done : bus.if_done) begin
                doneAt = c;
                break;
            end
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        if (doneAt < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int doneAt;
        int memAt;
        int ifAt;
        int nDone;
        int at[3];

        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.if_flush = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_size = 2'd0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < 65536; i++) ramMem[i] = 8'h00;
        ramMem[16'h1000] = 8'h78; ramMem[16'h1001] = 8'h56;
        ramMem[16'h1002] = 8'h34; ramMem[16'h1003] = 8'h12;
        ramMem[16'h0000] = 8'hBE; ramMem[16'h0001] = 8'hBA;
        ramMem[16'h0002] = 8'hFE; ramMem[16'h0003] = 8'hCA;
        ramMem[16'h2003] = 8'hF0; ramMem[16'h2004] = 8'h99;
        ramMem[16'h3002] = 8'h55;
        ramMem[16'h4000] = 8'h01; ramMem[16'h4001] = 8'h02;
        ramMem[16'h4002] = 8'h03; ramMem[16'h4003] = 8'h04;
        ramMem[16'hFFFE] = 8'hA1; ramMem[16'hFFFF] = 8'hA2;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        checkOutput("rst_ram_a", bus.ram_a, 32'd0);
        checkOutput("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        checkOutput("rst_if_done", 32'(bus.if_done), 32'd0);
        checkOutput("rst_mem_done", 32'(bus.mem_done), 32'd0);
        checkOutput("rst_if_data", bus.if_data, 32'd0);
        checkOutput("rst_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] word fetch at 0x1000");
        ifExp.push_back(32'h12345678);
        applyStimulus(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, doneAt);
        checkOutput("fetch_latency", 32'(doneAt), 32'd5);
        for (int k = 0; k < 4; k++) begin
            if (trA.size() > k) checkOutput("fetch_ram_a", trA[k], 32'h1000 + 32'(k));
        end
        idleCycles(2);

        $display("[TB] simultaneous IF and MEM byte load");
        memExp.push_back(32'h000000F0);
        ifExp.push_back(32'hCAFEBABE);
        bus.if_addr = 32'h0; bus.if_req = 1'b1;
        bus.mem_addr = 32'h2003; bus.mem_size = 2'd0; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
        memAt = -1;
        ifAt = -1;
        @(posedge clk); #1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (bus.mem_done && memAt < 0) begin memAt = c; bus.mem_req = 1'b0; end
            if (bus.if_done && ifAt < 0) begin ifAt = c; bus.if_req = 1'b0; break; end
        end
        bus.mem_req = 1'b0;
        bus.if_req = 1'b0;
        checkOutput("arb_mem_latency", 32'(memAt), 32'd2);
        checkOutput("arb_if_latency", 32'(ifAt), 32'd8);
        idleCycles(2);

        $display("[TB] half store at 0x3000");
        memExp.push_back(32'h000000F0);
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h3000, 32'hAABBCCDD, doneAt);
        checkOutput("hstore_latency", 32'(doneAt), 32'd2);
        checkOutput("hstore_wr_cycles", 32'(wrA.size()), 32'd2);
        if (wrA.size() == 2) begin
            checkOutput("hstore_a0", wrA[0], 32'h3000);
            checkOutput("hstore_d0", 32'(wrD[0]), 32'hDD);
            checkOutput("hstore_a1", wrA[1], 32'h3001);
            checkOutput("hstore_d1", 32'(wrD[1]), 32'hCC);
        end
        checkOutput("hstore_ram3002", 32'(ramMem[16'h3002]), 32'h55);
        idleCycles(2);

        $display("[TB] half load back from 0x3000");
        memExp.push_back(32'h0000CCDD);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h3000, 32'h0, doneAt);
        checkOutput("hload_latency", 32'(doneAt), 32'd3);
        idleCycles(2);

        $display("[TB] wrapping word fetch at 0xFFFFFFFE");
        ifExp.push_back(32'hBABEA2A1);
        applyStimulus(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, doneAt);
        checkOutput("wrap_latency", 32'(doneAt), 32'd5);
        if (trA.size() > 2) checkOutput("wrap_ram_a", trA[2], 32'h0);
        idleCycles(2);

        $display("[TB] flush during fetch");
        bus.if_addr = 32'h1000; bus.if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.if_flush = 1'b1;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("flush_busy_after", 32'(bus.busy), 32'd0);
        bus.if_flush = 1'b0;
        nDone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.if_done) nDone++;
        end
        checkOutput("flush_no_done", 32'(nDone), 32'd0);
        ifExp.push_back(32'h04030201);
        applyStimulus(1'b0, 1'b0, 2'd2, 32'h4000, 32'h0, doneAt);
        checkOutput("post_flush_latency", 32'(doneAt), 32'd5);
        idleCycles(2);

        $display("[TB] reset during word store");
        bus.mem_addr = 32'h5000; bus.mem_size = 2'd2; bus.mem_we = 1'b1;
        bus.mem_wdata = 32'h11223344; bus.mem_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.mem_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst2_ram_wr", 32'(bus.ram_wr), 32'd0);
        checkOutput("rst2_mem_done", 32'(bus.mem_done), 32'd0);
        checkOutput("rst2_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst2_ram_a", bus.ram_a, 32'd0);
        checkOutput("rst2_ram_dout", 32'(bus.ram_dout), 32'd0);
        checkOutput("rst2_if_data", bus.if_data, 32'd0);
        checkOutput("rst2_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b0;
        idleCycles(3);
        checkOutput("rst2_ram5000", 32'(ramMem[16'h5000]), 32'h44);
        checkOutput("rst2_ram5001", 32'(ramMem[16'h5001]), 32'h33);
        checkOutput("rst2_ram5002", 32'(ramMem[16'h5002]), 32'h00);
        checkOutput("rst2_ram5003", 32'(ramMem[16'h5003]), 32'h00);

        $display("[TB] held fetch request");
        for (int i = 0; i < 3; i++) ifExp.push_back(32'h12345678);
        bus.if_addr = 32'h1000; bus.if_req = 1'b1;
        nDone = 0;
        at[0] = -1; at[1] = -1; at[2] = -1;
        @(posedge clk); #1;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (bus.if_done) begin
                at[nDone] = c;
                nDone++;
                if (nDone == 3) begin
                    bus.if_req = 1'b0;
                    break;
                end
            end
        end
        bus.if_req = 1'b0;
        checkOutput("held_count", 32'(nDone), 32'd3);
        checkOutput("held_first", 32'(at[0]), 32'd5);
        checkOutput("held_second", 32'(at[1]), 32'd12);
        checkOutput("held_third", 32'(at[2]), 32'd19);
        nDone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.if_done) nDone++;
        end
        checkOutput("held_no_extra", 32'(nDone), 32'd0);
        checkOutput("if_queue_empty", 32'(ifExp.size()), 32'd0);
        checkOutput("mem_queue_empty", 32'(memExp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
